// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM encoding,
// word/lane geometry and the request address check.
package dmem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A request is rejected if it is not word aligned or addresses beyond the storage depth.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for the responder: one byte-wide memory per lane so each byte enable
// maps onto its own write port; read is combinational by word index.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [LANES-1:0]    wr_be,
    input  logic [ADDR_W-1:0]   rd_idx,
    output logic [WORD_W-1:0]   rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = lane_mem[rd_idx];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder with programmable wait states: one outstanding request,
// access performed when the wait counter expires, response held until handshake.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [WORD_W-1:0]   rdata_reg, rdata_next;
    logic                rsp_err_reg, rsp_err_next;

    logic                write_reg;
    logic                err_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [LANES-1:0]    be_reg;

    logic                accept;
    logic                req_err;
    logic                do_access;
    logic                acc_write;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_idx;
    logic [WORD_W-1:0]   acc_wdata;
    logic [LANES-1:0]    acc_be;
    logic                mem_wr_en;
    logic [WORD_W-1:0]   mem_rdata;

    assign accept  = req_valid && (state_reg == ST_IDLE);
    assign req_err = addr_err(req_addr, ADDR_W);

    // With zero wait states the access happens in the acceptance cycle, straight from the request.
    assign acc_write = (state_reg == ST_IDLE) ? req_write                 : write_reg;
    assign acc_err   = (state_reg == ST_IDLE) ? req_err                   : err_reg;
    assign acc_idx   = (state_reg == ST_IDLE) ? req_addr[ADDR_W+1:2]      : idx_reg;
    assign acc_wdata = (state_reg == ST_IDLE) ? req_wdata                 : wdata_reg;
    assign acc_be    = (state_reg == ST_IDLE) ? req_be                    : be_reg;

    // Reset in the commit cycle must drop the pending store.
    assign mem_wr_en = do_access && acc_write && !acc_err && !rst;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        do_access    = 1'b0;
        rdata_next   = rdata_reg;
        rsp_err_next = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Access fires on the cycle the counter reaches zero, giving WAIT_CYCLES+1 latency.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    do_access  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (do_access) begin
            rdata_next   = (acc_write || acc_err) ? '0 : mem_rdata;
            rsp_err_next = acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rdata_reg   <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rdata_reg   <= rdata_next;
            rsp_err_reg <= rsp_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_reg <= req_write;
            err_reg   <= req_err;
            idx_reg   <= req_addr[ADDR_W+1:2];
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_idx  (acc_idx),
        .wr_data (acc_wdata),
        .wr_be   (acc_be),
        .rd_idx  (acc_idx),
        .rd_data (mem_rdata)
    );

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
